// File: rtl/opl3_reg_write_queue.sv
// opl3_reg_write_queue
//
// Buffers host register writes (bank bit + register address + data) in a
// small circular FIFO and drains them into the write port of the synth's
// register-file RAM. A write is only committed in a cycle where the sample
// pipeline grants access, and consecutive RAM writes are separated by at
// least MIN_GAP idle cycles.
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-high reset
//   wr_valid   host presents a write
//   wr_ready   queue can accept (transfer on wr_valid && wr_ready)
//   wr_addr    host register address (bit 8 = OPL3 bank)
//   wr_data    host register data
//   commit_en  pipeline grants RAM write access this cycle
//   wea        RAM write enable (registered, 1-cycle pulses)
//   addra      RAM write address (registered, holds while wea=0)
//   dia        RAM write data (registered, holds while wea=0)
//   fill       current FIFO occupancy
//   pending    queue not empty or a RAM write is in flight
//
// Drain FSM states:
//   state  | meaning
//   S_IDLE | may pop the head entry when non-empty and commit_en is high
//   S_GAP  | enforcing idle cycles after a commit; commit_en ignored

module opl3_reg_write_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int MIN_GAP    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      commit_en,
  output logic                      wea,
  output logic [ADDR_WIDTH-1:0]     addra,
  output logic [DATA_WIDTH-1:0]     dia,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      pending
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int GAP_W  = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   wea_d;
  logic [ADDR_WIDTH-1:0]  addra_d;
  logic [DATA_WIDTH-1:0]  dia_d;
  logic                   push, pop;

  logic [ADDR_WIDTH-1:0]  mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data [DEPTH];

  // Ready depends only on registered occupancy: a pop in the same cycle
  // does not free a slot for the host until the following cycle.
  assign wr_ready = (fill_q < FILL_FULL) && !reset;
  assign push     = wr_valid && wr_ready;
  assign fill     = fill_q;
  assign pending  = (fill_q != '0) || wea;

  // Storage has no reset; discarding entries is done through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= wr_addr;
      mem_data[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    wea_d     = 1'b0;
    addra_d   = addra;
    dia_d     = dia;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // fill_q is registered, so an entry pushed this cycle into an empty
        // queue cannot be popped until the next cycle.
        if ((fill_q != '0) && commit_en) begin
          pop     = 1'b1;
          wea_d   = 1'b1;
          addra_d = mem_addr[rd_ptr_q];
          dia_d   = mem_data[rd_ptr_q];
          if (MIN_GAP != 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        // Leaving on the edge where the count is 1 yields exactly MIN_GAP
        // idle cycles, i.e. one commit every MIN_GAP+1 cycles.
        if (gap_cnt_q <= GAP_ONE) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      wea       <= 1'b0;
      addra     <= '0;
      dia       <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      wea       <= wea_d;
      addra     <= addra_d;
      dia       <= dia_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FILL_ONE;
        2'b01:   fill_q <= fill_q - FILL_ONE;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_opl3_reg_write_queue.sv
// tb_opl3_reg_write_queue
//
// Directed bench for opl3_reg_write_queue. Three instances share all inputs:
// u_dut_a (MIN_GAP=2, default), u_dut_b (MIN_GAP=3) and u_dut_c (MIN_GAP=0).
// Host handshakes follow u_dut_a; the other two are only observed for
// pacing after a common reset and identical preload.

module tb_opl3_reg_write_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit_en;

  logic       a_wr_ready, a_wea, a_pending;
  logic [8:0] a_addra;
  logic [7:0] a_dia;
  logic [3:0] a_fill;
  logic       b_wr_ready, b_wea, b_pending;
  logic [8:0] b_addra;
  logic [7:0] b_dia;
  logic [3:0] b_fill;
  logic       c_wr_ready, c_wea, c_pending;
  logic [8:0] c_addra;
  logic [7:0] c_dia;
  logic [3:0] c_fill;

  always #5 clk = ~clk;

  opl3_reg_write_queue #(.DEPTH(8), .ADDR_WIDTH(9), .DATA_WIDTH(8), .MIN_GAP(2)) u_dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en),
    .wea(a_wea), .addra(a_addra), .dia(a_dia), .fill(a_fill), .pending(a_pending)
  );

  opl3_reg_write_queue #(.DEPTH(8), .ADDR_WIDTH(9), .DATA_WIDTH(8), .MIN_GAP(3)) u_dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en),
    .wea(b_wea), .addra(b_addra), .dia(b_dia), .fill(b_fill), .pending(b_pending)
  );

  opl3_reg_write_queue #(.DEPTH(8), .ADDR_WIDTH(9), .DATA_WIDTH(8), .MIN_GAP(0)) u_dut_c (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(c_wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_en(commit_en),
    .wea(c_wea), .addra(c_addra), .dia(c_dia), .fill(c_fill), .pending(c_pending)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [16:0] got_q[$];
  int          got_t[$];
  int          bt_q[$];
  int          ct_q[$];
  logic [16:0] exp_q[$];
  int          gb, bb, cb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (a_wea) begin
        got_q.push_back({a_addra, a_dia});
        got_t.push_back(cyc);
      end
      if (b_wea) bt_q.push_back(cyc);
      if (c_wea) ct_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_test;
    reset     = 1'b1;
    wr_valid  = 1'b0;
    commit_en = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    gb = got_q.size();
    bb = bt_q.size();
    cb = ct_q.size();
    exp_q.delete();
  endtask

  task automatic push_n(input string tag, input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      wr_addr  = 9'(seed * 37 + i * 11);
      wr_data  = 8'(seed * 5 + i * 29 + 1);
      wr_valid = 1'b1;
      check_val($sformatf("%s_ready_%0d", tag, i), a_wr_ready, 1);
      tick();
      exp_q.push_back({wr_addr, wr_data});
    end
    wr_valid = 1'b0;
  endtask

  // commit_en must already be high and the FSM idle with an empty queue.
  task automatic single_write(input string tag, input logic [8:0] addr, input logic [7:0] data);
    wr_addr  = addr;
    wr_data  = data;
    wr_valid = 1'b1;
    check_val({tag, "_ready"}, a_wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check_val({tag, "_fill_acc"}, a_fill, 1);
    check_val({tag, "_wea_acc"}, a_wea, 0);
    tick();
    check_val({tag, "_wea"}, a_wea, 1);
    check_val({tag, "_addra"}, a_addra, addr);
    check_val({tag, "_dia"}, a_dia, data);
    check_val({tag, "_fill_pop"}, a_fill, 0);
    check_val({tag, "_pend_busy"}, a_pending, 1);
    tick();
    check_val({tag, "_wea_off"}, a_wea, 0);
    check_val({tag, "_pend_done"}, a_pending, 0);
    check_val({tag, "_addra_hold"}, a_addra, addr);
    check_val({tag, "_dia_hold"}, a_dia, data);
  endtask

  task automatic wait_drain(input string tag, input int n);
    for (int k = 0; k < 300 && !((got_q.size() - gb) >= n && !a_pending); k++) tick();
    check_val({tag, "_drain"}, got_q.size() - gb, n);
  endtask

  task automatic cmp_order(input string tag);
    check_val({tag, "_count"}, got_q.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (gb + i < got_q.size())
        check_val($sformatf("%s_entry_%0d", tag, i), got_q[gb + i], exp_q[i]);
    end
  endtask

  task automatic cmp_spacing(input string tag, input int period, input int n);
    for (int i = 1; i < n; i++) begin
      if (gb + i < got_t.size())
        check_val($sformatf("%s_gap_%0d", tag, i), got_t[gb + i] - got_t[gb + i - 1], period);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic acc;

    // reset values
    reset     = 1'b1;
    wr_valid  = 1'b0;
    commit_en = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tick();
    tick();
    check_val("rst_wea", a_wea, 0);
    check_val("rst_addra", a_addra, 0);
    check_val("rst_dia", a_dia, 0);
    check_val("rst_fill", a_fill, 0);
    check_val("rst_pending", a_pending, 0);
    check_val("rst_wr_ready", a_wr_ready, 0);
    reset = 1'b0;
    #1;
    check_val("rst_rel_ready", a_wr_ready, 1);

    // single write
    start_test();
    commit_en = 1'b1;
    single_write("single", 9'h1A0, 8'h55);

    // full stall, 9th write accepted on the edge after the first pop
    start_test();
    push_n("stall", 8, 1);
    check_val("stall_fill8", a_fill, 8);
    check_val("stall_ready0", a_wr_ready, 0);
    wr_addr  = 9'h1FF;
    wr_data  = 8'h99;
    wr_valid = 1'b1;
    tick();
    tick();
    check_val("stall_held_fill", a_fill, 8);
    check_val("stall_held_ready", a_wr_ready, 0);
    check_val("stall_held_wea", a_wea, 0);
    commit_en = 1'b1;
    tick();
    check_val("stall_pop_wea", a_wea, 1);
    check_val("stall_pop_fill", a_fill, 7);
    check_val("stall_pop_ready", a_wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    exp_q.push_back({9'h1FF, 8'h99});
    check_val("stall_9th_fill", a_fill, 8);
    wait_drain("stall", 9);
    cmp_order("stall");
    cmp_spacing("stall_pace", 3, 9);

    // pacing for MIN_GAP = 2, 3 and 0
    start_test();
    push_n("pace", 4, 2);
    commit_en = 1'b1;
    repeat (20) tick();
    check_val("pace_a_n", got_t.size() - gb, 4);
    check_val("pace_b_n", bt_q.size() - bb, 4);
    check_val("pace_c_n", ct_q.size() - cb, 4);
    cmp_spacing("pace_a", 3, 4);
    for (int i = 1; i < 4; i++) begin
      if (bb + i < bt_q.size())
        check_val($sformatf("pace_b_gap_%0d", i), bt_q[bb + i] - bt_q[bb + i - 1], 4);
      if (cb + i < ct_q.size())
        check_val($sformatf("pace_c_gap_%0d", i), ct_q[cb + i] - ct_q[cb + i - 1], 1);
    end
    cmp_order("pace");

    // grant gating: commit_en high 1 cycle in 5
    start_test();
    push_n("gate", 3, 3);
    for (int k = 0; k < 25; k++) begin
      commit_en = (k % 5 == 0);
      tick();
      check_val($sformatf("gate_wea_k%0d", k), a_wea, ((k % 5 == 0) && (k < 15)) ? 1 : 0);
    end
    commit_en = 1'b0;
    cmp_order("gate");

    // reset in the middle of a burst
    start_test();
    push_n("mid", 5, 4);
    commit_en = 1'b1;
    tick();
    check_val("mid_wea_before", a_wea, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_wea_async", a_wea, 0);
    check_val("mid_fill_async", a_fill, 0);
    check_val("mid_pend_async", a_pending, 0);
    check_val("mid_ready_async", a_wr_ready, 0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_val("mid_no_stale", got_q.size() - gb, 0);
    check_val("mid_fill_after", a_fill, 0);
    single_write("mid_new", 9'h005, 8'hAA);

    // pointer wrap: steady push+pop at fill=1, then a saturating burst
    start_test();
    commit_en = 1'b1;
    wr_addr   = 9'h100;
    wr_data   = 8'h01;
    wr_valid  = 1'b1;
    tick();
    exp_q.push_back({9'h100, 8'h01});
    check_val("wrap_first_fill", a_fill, 1);
    for (int i = 1; i < 14; i++) begin
      wr_addr  = 9'(i * 7 + 3) | 9'((i & 1) << 8);
      wr_data  = 8'(i * 13 + 1);
      wr_valid = 1'b1;
      check_val($sformatf("wrap_ready_%0d", i), a_wr_ready, 1);
      tick();
      exp_q.push_back({wr_addr, wr_data});
      check_val($sformatf("wrap_fill1_%0d", i), a_fill, 1);
      wr_valid = 1'b0;
      tick();
      tick();
    end
    idx = 14;
    for (int k = 0; k < 200 && idx < 27; k++) begin
      wr_addr  = 9'(idx * 7 + 3) | 9'((idx & 1) << 8);
      wr_data  = 8'(idx * 13 + 1);
      wr_valid = 1'b1;
      acc = a_wr_ready;
      tick();
      if (acc) begin
        exp_q.push_back({wr_addr, wr_data});
        idx++;
      end
      check_val($sformatf("wrap_fill_le_depth_%0d", k), (a_fill <= 4'd8) ? 1 : 0, 1);
    end
    wr_valid = 1'b0;
    check_val("wrap_pushed", idx, 27);
    wait_drain("wrap", 27);
    cmp_order("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
